patch_reducer_mc: RTL and testbench
===================================

# patch_reducer_mc

Multi-channel patch accumulator between the row-sum stage and the patch-result consumer, running in the DRAM clock domain. Up to N_CH patches are reduced concurrently. Each channel sums a runtime-configured number of tagged row partial sums, with optional saturation. Completed sums leave through one registered, round-robin-arbitrated output port with a valid/ack handshake.

## Interface
- N_CH, 4: number of independent patch channels (≥1)
- MAX_PATCH_SIZE, 6: largest patch height (rows) accepted at init
- ROW_SUM_SIZE, 16: partial_sum width
- PATCH_SUM_SIZE, 24: accumulator and sum width (≥ ROW_SUM_SIZE)
- SATURATE, 1: 1 clamps accumulation at all-ones; 0 wraps modulo 2^PATCH_SUM_SIZE
- CW (derived) = max(1, ceil(log2(N_CH))); RW (derived) = ceil(log2(MAX_PATCH_SIZE+1))

Ports:
- dram_clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, asynchronous, active-high
- init  in  1  start a patch on channel init_ch
- init_ch  in  CW  target channel for init
- cfg_patch_size  in  RW  rows in the patch, legal 1..MAX_PATCH_SIZE
- partial_sum  in  ROW_SUM_SIZE  unsigned row sum
- partial_sum_valid  in  1  partial_sum and ps_ch are valid this cycle
- ps_ch  in  CW  channel that partial_sum belongs to
- sum_rdy  out  1  output register holds a completed patch
- sum  out  PATCH_SUM_SIZE  completed patch sum
- sum_ch  out  CW  channel that produced sum
- sum_sat  out  1  saturation occurred while accumulating sum
- sum_ack  in  1  consumer takes the output; meaningful only while sum_rdy=1
- protocol_err  out  1  one-cycle pulse flagging an illegal or ignored request

## Operation
- Per-channel state: IDLE, ACCUM, DONE. Each channel also holds an accumulator, a row counter, a latched patch size and a sat flag.
- IDLE→ACCUM on init with init_ch = c and a legal cfg_patch_size. On that edge: acc←0, rows←0, size←cfg_patch_size, sat←0.
- init is ignored and protocol_err pulses when:
  - the target channel is not IDLE,
  - cfg_patch_size is 0 or greater than MAX_PATCH_SIZE, or
  - init_ch ≥ N_CH.
- ACCUM, on partial_sum_valid with ps_ch = c:
  - acc ← acc + zero-extended partial_sum; rows ← rows+1.
  - With SATURATE=1 and a carry out, acc ← all-ones and sat ← 1.
  - If rows = size−1 before the increment, the channel goes to DONE.
- A partial_sum_valid tagged to a channel not in ACCUM, or with ps_ch ≥ N_CH, is dropped and protocol_err pulses.
- Only one init and one partial_sum arrive per cycle. Both may arrive in the same cycle and are handled independently, even when they target the same channel: init is rejected for a busy channel, and the partial sum is rejected for an IDLE channel.
- Output stage:
  - The output register is "free" when sum_rdy=0, or when sum_rdy=1 and sum_ack=1.
  - While free, the arbiter grants the first DONE channel at or after rr_ptr (cyclic order).
  - On the grant edge, acc, channel index and sat load into sum, sum_ch and sum_sat. The granted channel → IDLE, and rr_ptr ← granted+1 mod N_CH.
  - If nothing is granted and sum_ack=1, sum_rdy → 0.
- sum, sum_ch and sum_sat hold stable while sum_rdy=1 and sum_ack=0.
- Reset in any state: all channels IDLE, accumulators 0, rr_ptr 0, and every output at its reset value. A patch in flight is discarded.

## Timing
- Reset values: sum_rdy=0, sum=0, sum_ch=0, sum_sat=0, protocol_err=0.
- init sampled at edge k → channel in ACCUM from cycle k+1; a partial_sum may be presented in cycle k+1.
- Last row sampled at edge m → channel DONE in cycle m+1 → with the output free, sum_rdy=1 from cycle m+2. Minimum latency is 2 cycles after the last valid row.
- Back-to-back: with sum_ack=1 and another channel DONE, sum_rdy stays 1 and the new sum/sum_ch appear the next cycle. Throughput is one patch per cycle.
- A granted channel is IDLE from the cycle after the grant. An init for it in the grant cycle is rejected (protocol_err).
- protocol_err is registered: high exactly the cycle after the offending request.
- sum_ack while sum_rdy=0 is ignored, with no error.

## Test plan
- Single patch (N_CH=4, size 6): init ch2, rows 1..6 on ch2 → sum_rdy 2 cycles after the last row, sum=21, sum_ch=2, sum_sat=0. Hold 3 cycles without ack → values stable. Ack → sum_rdy=0 next cycle.
- Interleaved channels: init ch0 size 2 and ch1 size 3; alternate rows 10/100 → ch0 sum=20, ch1 sum=300; each completes in order of its last row.
- Round-robin: ch0–ch3 all DONE with sum_ack held 1 → sums emerge ch0, ch1, ch2, ch3 on consecutive cycles. Next grant after a ch3 grant starts from ch0.
- Saturation (PATCH_SUM_SIZE=16, ROW_SUM_SIZE=16, size 2): rows 0xFFFF and 0x0002 → SATURATE=1 gives 0xFFFF with sum_sat=1; SATURATE=0 gives 0x0001 with sum_sat=0.
- Errors: each of the following → protocol_err one-cycle pulse, no state change:
  - init on an ACCUM channel,
  - init with cfg_patch_size 0,
  - init with cfg_patch_size 7 (MAX 6),
  - partial_sum to an IDLE channel.
- Reset mid-patch: assert reset after 3 of 6 rows on ch1 → all outputs 0 immediately. After release, init ch1 with a new patch of rows all 1 → sum=6.

Source files
------------

// File: rtl/patch_reducer_mc_if.sv
// Handshake bundle between the row-sum stage, the patch reducer and the
// patch-result consumer.
interface patch_reducer_mc_if #(
   parameter int N_CH           = 4,
   parameter int MAX_PATCH_SIZE = 6,
   parameter int ROW_SUM_SIZE   = 16,
   parameter int PATCH_SUM_SIZE = 24
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RW = $clog2(MAX_PATCH_SIZE + 1);

   logic                      init;
   logic [CW-1:0]             init_ch;
   logic [RW-1:0]             cfg_patch_size;
   logic [ROW_SUM_SIZE-1:0]   partial_sum;
   logic                      partial_sum_valid;
   logic [CW-1:0]             ps_ch;
   logic                      sum_rdy;
   logic [PATCH_SUM_SIZE-1:0] sum;
   logic [CW-1:0]             sum_ch;
   logic                      sum_sat;
   logic                      sum_ack;
   logic                      protocol_err;

   modport master (
      output init, init_ch, cfg_patch_size, partial_sum, partial_sum_valid, ps_ch, sum_ack,
      input  sum_rdy, sum, sum_ch, sum_sat, protocol_err
   );

   modport slave (
      input  init, init_ch, cfg_patch_size, partial_sum, partial_sum_valid, ps_ch, sum_ack,
      output sum_rdy, sum, sum_ch, sum_sat, protocol_err
   );
endinterface

// File: rtl/patch_reducer_mc.sv
// Multi-channel patch accumulator: per-channel row summing with optional
// saturation, one round-robin arbitrated registered output port.
//
// state    | meaning
// ST_IDLE  | channel free, accepts init
// ST_ACCUM | channel summing tagged partial sums
// ST_DONE  | patch complete, waiting for an output grant
module patch_reducer_mc #(
   parameter int N_CH           = 4,
   parameter int MAX_PATCH_SIZE = 6,
   parameter int ROW_SUM_SIZE   = 16,
   parameter int PATCH_SUM_SIZE = 24,
   parameter bit SATURATE       = 1'b1
) (
   input logic              dram_clk,
   input logic              reset,
   patch_reducer_mc_if.slave bus
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RW = $clog2(MAX_PATCH_SIZE + 1);
   localparam logic [CW:0]   NCH_W  = (CW+1)'(N_CH);
   localparam logic [RW-1:0] MAX_SZ = RW'(MAX_PATCH_SIZE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } ch_state_e;

   ch_state_e                 state_q [N_CH];
   ch_state_e                 state_d [N_CH];
   logic [PATCH_SUM_SIZE-1:0] acc_q   [N_CH];
   logic [PATCH_SUM_SIZE-1:0] acc_d   [N_CH];
   logic [RW-1:0]             rows_q  [N_CH];
   logic [RW-1:0]             rows_d  [N_CH];
   logic [RW-1:0]             size_q  [N_CH];
   logic [RW-1:0]             size_d  [N_CH];
   logic                      sat_q   [N_CH];
   logic                      sat_d   [N_CH];

   logic [CW-1:0]             rr_ptr_q, rr_ptr_d;
   logic                      sum_rdy_q, sum_rdy_d;
   logic [PATCH_SUM_SIZE-1:0] sum_q, sum_d;
   logic [CW-1:0]             sum_ch_q, sum_ch_d;
   logic                      sum_sat_q, sum_sat_d;
   logic                      perr_q, perr_d;

   logic                      init_req_ok, ps_req_ok, size_ok;
   logic                      init_ok, ps_ok;
   logic                      out_free, gnt_vld;
   logic [CW-1:0]             gnt_ch;
   logic [PATCH_SUM_SIZE:0]   acc_sum;
   int                        idx;

   assign init_req_ok = bus.init && ({1'b0, bus.init_ch} < NCH_W);
   assign ps_req_ok   = bus.partial_sum_valid && ({1'b0, bus.ps_ch} < NCH_W);
   assign size_ok     = (bus.cfg_patch_size != '0) && (bus.cfg_patch_size <= MAX_SZ);

   always_ff @(posedge dram_clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < N_CH; c++) begin
            state_q[c] <= ST_IDLE;
            acc_q[c]   <= '0;
            rows_q[c]  <= '0;
            size_q[c]  <= '0;
            sat_q[c]   <= 1'b0;
         end
         rr_ptr_q  <= '0;
         sum_rdy_q <= 1'b0;
         sum_q     <= '0;
         sum_ch_q  <= '0;
         sum_sat_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            state_q[c] <= state_d[c];
            acc_q[c]   <= acc_d[c];
            rows_q[c]  <= rows_d[c];
            size_q[c]  <= size_d[c];
            sat_q[c]   <= sat_d[c];
         end
         rr_ptr_q  <= rr_ptr_d;
         sum_rdy_q <= sum_rdy_d;
         sum_q     <= sum_d;
         sum_ch_q  <= sum_ch_d;
         sum_sat_q <= sum_sat_d;
         perr_q    <= perr_d;
      end
   end

   always_comb begin
      init_ok   = 1'b0;
      ps_ok     = 1'b0;
      gnt_vld   = 1'b0;
      gnt_ch    = '0;
      acc_sum   = '0;
      idx       = 0;
      rr_ptr_d  = rr_ptr_q;
      sum_rdy_d = sum_rdy_q;
      sum_d     = sum_q;
      sum_ch_d  = sum_ch_q;
      sum_sat_d = sum_sat_q;
      out_free  = !sum_rdy_q || bus.sum_ack;
      for (int c = 0; c < N_CH; c++) begin
         state_d[c] = state_q[c];
         acc_d[c]   = acc_q[c];
         rows_d[c]  = rows_q[c];
         size_d[c]  = size_q[c];
         sat_d[c]   = sat_q[c];
      end

      // init and partial sum are judged against the current state only, so a
      // same-cycle pair on one channel never sees each other's effect
      for (int c = 0; c < N_CH; c++) begin
         if (init_req_ok && size_ok && bus.init_ch == CW'(c) && state_q[c] == ST_IDLE) begin
            init_ok    = 1'b1;
            state_d[c] = ST_ACCUM;
            acc_d[c]   = '0;
            rows_d[c]  = '0;
            size_d[c]  = bus.cfg_patch_size;
            sat_d[c]   = 1'b0;
         end
         if (ps_req_ok && bus.ps_ch == CW'(c) && state_q[c] == ST_ACCUM) begin
            ps_ok   = 1'b1;
            acc_sum = {1'b0, acc_q[c]} + (PATCH_SUM_SIZE+1)'(bus.partial_sum);
            if (SATURATE && acc_sum[PATCH_SUM_SIZE]) begin
               acc_d[c] = '1;
               sat_d[c] = 1'b1;
            end else begin
               acc_d[c] = acc_sum[PATCH_SUM_SIZE-1:0];
            end
            rows_d[c] = rows_q[c] + RW'(1);
            if (rows_q[c] == size_q[c] - RW'(1)) begin
               state_d[c] = ST_DONE;
            end
         end
      end

      if (out_free) begin
         for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_CH;
            if (!gnt_vld && state_q[idx] == ST_DONE) begin
               gnt_vld = 1'b1;
               gnt_ch  = CW'(idx);
            end
         end
         if (gnt_vld) begin
            for (int c = 0; c < N_CH; c++) begin
               if (gnt_ch == CW'(c)) begin
                  sum_d      = acc_q[c];
                  sum_sat_d  = sat_q[c];
                  state_d[c] = ST_IDLE;
               end
            end
            sum_ch_d  = gnt_ch;
            sum_rdy_d = 1'b1;
            rr_ptr_d  = CW'((int'(gnt_ch) + 1) % N_CH);
         end else if (bus.sum_ack) begin
            sum_rdy_d = 1'b0;
         end
      end

      perr_d = (bus.init && !init_ok) || (bus.partial_sum_valid && !ps_ok);
   end

   assign bus.sum_rdy      = sum_rdy_q;
   assign bus.sum          = sum_q;
   assign bus.sum_ch       = sum_ch_q;
   assign bus.sum_sat      = sum_sat_q;
   assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_patch_reducer_mc.sv
// Scoreboard bench for patch_reducer_mc: a cycle-level behavioural model
// predicts outputs; a separate monitor compares them as the DUT presents them.
module tb_patch_reducer_mc;
   localparam int     N_CH = 4;
   localparam int     MAXP = 6;
   localparam int     PSW  = 24;
   localparam bit     MSAT = 1'b1;
   localparam longint PMAX = (longint'(1) << PSW) - 1;

   logic dram_clk = 1'b0;
   logic reset    = 1'b1;
   always #5 dram_clk = ~dram_clk;

   patch_reducer_mc_if #(.N_CH(N_CH), .MAX_PATCH_SIZE(MAXP), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(PSW)) bus();
   patch_reducer_mc_if #(.N_CH(N_CH), .MAX_PATCH_SIZE(MAXP), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16)) bus_s1();
   patch_reducer_mc_if #(.N_CH(N_CH), .MAX_PATCH_SIZE(MAXP), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16)) bus_s0();

   patch_reducer_mc #(.N_CH(N_CH), .MAX_PATCH_SIZE(MAXP), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(PSW),
                      .SATURATE(1'b1)) dut (.dram_clk(dram_clk), .reset(reset), .bus(bus));
   patch_reducer_mc #(.N_CH(N_CH), .MAX_PATCH_SIZE(MAXP), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16),
                      .SATURATE(1'b1)) dut_s1 (.dram_clk(dram_clk), .reset(reset), .bus(bus_s1));
   patch_reducer_mc #(.N_CH(N_CH), .MAX_PATCH_SIZE(MAXP), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16),
                      .SATURATE(1'b0)) dut_s0 (.dram_clk(dram_clk), .reset(reset), .bus(bus_s0));

   int n_total = 0;
   int n_bad   = 0;
   bit mon_en  = 1'b0;
   bit prev_rdy = 1'b0;

   typedef struct { int ch; longint sum; bit sat; } out_t;
   typedef struct { bit rdy; bit err; } st_t;
   out_t out_q[$];
   st_t  st_q[$];
   out_t out_log[$];
   out_t cur;

   typedef enum int {M_IDLE, M_ACC, M_DONE} mst_e;
   mst_e   m_st[N_CH];
   longint m_acc[N_CH];
   int     m_rows[N_CH];
   int     m_size[N_CH];
   bit     m_sat[N_CH];
   bit     m_rdy;
   int     m_rr;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_st[c] = M_IDLE; m_acc[c] = 0; m_rows[c] = 0; m_size[c] = 0; m_sat[c] = 1'b0;
      end
      m_rdy = 1'b0;
      m_rr  = 0;
   endtask

   // One clock edge of the reference behaviour, evaluated on the pre-edge state.
   task automatic model_step(input bit ini, input int ich, input int isz,
                             input bit psv, input int pch, input longint ps, input bit ack);
      mst_e pre[N_CH];
      bit   err = 1'b0;
      int   g = -1;
      for (int c = 0; c < N_CH; c++) pre[c] = m_st[c];
      if (ini) begin
         if (ich < N_CH && isz >= 1 && isz <= MAXP && pre[ich] == M_IDLE) begin
            m_st[ich] = M_ACC; m_acc[ich] = 0; m_rows[ich] = 0; m_size[ich] = isz; m_sat[ich] = 1'b0;
         end else err = 1'b1;
      end
      if (psv) begin
         if (pch < N_CH && pre[pch] == M_ACC) begin
            m_acc[pch] += ps;
            if (m_acc[pch] > PMAX) begin
               if (MSAT) begin m_acc[pch] = PMAX; m_sat[pch] = 1'b1; end
               else m_acc[pch] -= (PMAX + 1);
            end
            m_rows[pch]++;
            if (m_rows[pch] == m_size[pch]) m_st[pch] = M_DONE;
         end else err = 1'b1;
      end
      if (!m_rdy || ack) begin
         for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_rr + k) % N_CH;
            if (g < 0 && pre[c] == M_DONE) g = c;
         end
         if (g >= 0) begin
            out_q.push_back('{g, m_acc[g], m_sat[g]});
            m_st[g] = M_IDLE;
            m_rr    = (g + 1) % N_CH;
            m_rdy   = 1'b1;
         end else m_rdy = 1'b0;
      end
      st_q.push_back('{m_rdy, err});
   endtask

   task automatic cyc(input bit ini, input int ich, input int isz,
                      input bit psv, input int pch, input longint ps, input bit ack);
      bus.init = ini; bus.init_ch = 2'(ich); bus.cfg_patch_size = 3'(isz);
      bus.partial_sum_valid = psv; bus.ps_ch = 2'(pch); bus.partial_sum = 16'(ps);
      bus.sum_ack = ack;
      model_step(ini, ich, isz, psv, pch, ps, ack);
      @(posedge dram_clk); #3;
   endtask

   task automatic idle(input int n, input bit ack);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 0, 0, ack);
   endtask

   task automatic set_idle();
      bus.init = 1'b0; bus.init_ch = '0; bus.cfg_patch_size = '0;
      bus.partial_sum_valid = 1'b0; bus.ps_ch = '0; bus.partial_sum = '0; bus.sum_ack = 1'b0;
   endtask

   task automatic sat_drive(input bit ini, input bit psv, input logic [15:0] ps);
      bus_s1.init = ini; bus_s1.init_ch = '0; bus_s1.cfg_patch_size = 3'd2;
      bus_s1.partial_sum_valid = psv; bus_s1.ps_ch = '0; bus_s1.partial_sum = ps; bus_s1.sum_ack = 1'b0;
      bus_s0.init = ini; bus_s0.init_ch = '0; bus_s0.cfg_patch_size = 3'd2;
      bus_s0.partial_sum_valid = psv; bus_s0.ps_ch = '0; bus_s0.partial_sum = ps; bus_s0.sum_ack = 1'b0;
   endtask

   task automatic apply_reset();
      mon_en = 1'b0;
      set_idle();
      #2 reset = 1'b1;
      #1;
      chk("rst_sum_rdy", bus.sum_rdy, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_sum_ch", bus.sum_ch, 0);
      chk("rst_sum_sat", bus.sum_sat, 0);
      chk("rst_protocol_err", bus.protocol_err, 0);
      model_reset();
      out_q.delete();
      st_q.delete();
      prev_rdy = 1'b0;
      @(posedge dram_clk); @(posedge dram_clk); #3;
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   initial begin : monitor
      st_t s;
      forever begin
         @(posedge dram_clk); #1;
         if (mon_en) begin
            if (st_q.size() > 0) begin
               s = st_q.pop_front();
               chk("sum_rdy", bus.sum_rdy, s.rdy);
               chk("protocol_err", bus.protocol_err, s.err);
            end
            if (bus.sum_rdy && (!prev_rdy || bus.sum_ack)) begin
               if (out_q.size() == 0) begin
                  n_total++; n_bad++;
                  $display("FAIL unexpected_output: got ch=%0d sum=%0h, expected none", bus.sum_ch, bus.sum);
               end else begin
                  cur = out_q.pop_front();
                  chk("out_ch", bus.sum_ch, cur.ch);
                  chk("out_sum", bus.sum, cur.sum);
                  chk("out_sat", bus.sum_sat, cur.sat);
                  out_log.push_back('{int'(bus.sum_ch), longint'(bus.sum), bus.sum_sat});
               end
            end else if (bus.sum_rdy) begin
               chk("hold_sum", bus.sum, cur.sum);
               chk("hold_ch", bus.sum_ch, cur.ch);
            end
            prev_rdy = bus.sum_rdy;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int exp_rr[4];
      exp_rr = '{3, 0, 1, 2};
      set_idle();
      sat_drive(1'b0, 1'b0, 16'h0);
      model_reset();
      repeat (3) @(posedge dram_clk);
      #3 reset = 1'b0;
      chk("init_sum_rdy", bus.sum_rdy, 0);
      chk("init_sum", bus.sum, 0);
      chk("init_sum_ch", bus.sum_ch, 0);
      chk("init_sum_sat", bus.sum_sat, 0);
      chk("init_protocol_err", bus.protocol_err, 0);
      mon_en = 1'b1;

      // round robin: ch3 wins alone, then ch0..ch2 drain back to back from rr=0
      for (int c = 0; c < 4; c++) cyc(1'b1, c, 1, 1'b0, 0, 0, 1'b0);
      for (int c = 3; c >= 0; c--) cyc(1'b0, 0, 0, 1'b1, c, 7 + (3 - c), 1'b0);
      idle(3, 1'b0);
      idle(5, 1'b1);
      chk("rr_count", out_log.size(), 4);
      for (int k = 0; k < 4 && k < out_log.size(); k++) chk("rr_order", out_log[k].ch, exp_rr[k]);
      out_log.delete();

      // single patch on ch2, rows 1..6
      cyc(1'b1, 2, 6, 1'b0, 0, 0, 1'b0);
      for (int r = 1; r <= 6; r++) cyc(1'b0, 0, 0, 1'b1, 2, r, 1'b0);
      chk("single_lat_m1", bus.sum_rdy, 0);
      idle(1, 1'b0);
      chk("single_lat_rdy", bus.sum_rdy, 1);
      chk("single_sum", bus.sum, 21);
      chk("single_ch", bus.sum_ch, 2);
      chk("single_sat", bus.sum_sat, 0);
      idle(3, 1'b0);
      chk("single_hold", bus.sum, 21);
      idle(1, 1'b1);
      chk("single_ack_clear", bus.sum_rdy, 0);
      out_log.delete();

      // interleaved ch0 (size 2) and ch1 (size 3)
      cyc(1'b1, 0, 2, 1'b0, 0, 0, 1'b1);
      cyc(1'b1, 1, 3, 1'b0, 0, 0, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 0, 10, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1, 100, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 0, 10, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1, 100, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1, 100, 1'b1);
      idle(4, 1'b1);
      chk("ilv_count", out_log.size(), 2);
      if (out_log.size() == 2) begin
         chk("ilv_first_ch", out_log[0].ch, 0);
         chk("ilv_first_sum", out_log[0].sum, 20);
         chk("ilv_second_ch", out_log[1].ch, 1);
         chk("ilv_second_sum", out_log[1].sum, 300);
      end

      // protocol errors
      cyc(1'b1, 3, 2, 1'b0, 0, 0, 1'b1);
      cyc(1'b1, 3, 4, 1'b0, 0, 0, 1'b1);
      chk("err_init_busy", bus.protocol_err, 1);
      idle(1, 1'b1);
      chk("err_pulse_end", bus.protocol_err, 0);
      cyc(1'b1, 0, 0, 1'b0, 0, 0, 1'b1);
      chk("err_size0", bus.protocol_err, 1);
      cyc(1'b1, 0, 7, 1'b0, 0, 0, 1'b1);
      chk("err_size7", bus.protocol_err, 1);
      cyc(1'b0, 0, 0, 1'b1, 0, 55, 1'b1);
      chk("err_ps_idle", bus.protocol_err, 1);
      cyc(1'b1, 1, 2, 1'b1, 1, 9, 1'b1);
      chk("err_same_cycle", bus.protocol_err, 1);
      cyc(1'b0, 0, 0, 1'b1, 3, 5, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 3, 6, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1, 1, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1, 2, 1'b1);
      idle(4, 1'b1);

      // randomized traffic
      for (int i = 0; i < 700; i++) begin
         bit ini, psv, ack;
         int ich, isz, pch;
         longint ps;
         ini = ($urandom_range(0, 2) == 0);
         ich = $urandom_range(0, 3);
         isz = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 6);
         psv = ($urandom_range(0, 3) != 0);
         pch = $urandom_range(0, 3);
         ps  = ($urandom_range(0, 3) == 0) ? 65535 : $urandom_range(0, 65535);
         ack = ($urandom_range(0, 2) != 0);
         cyc(ini, ich, isz, psv, pch, ps, ack);
      end
      idle(10, 1'b1);

      // reset mid-patch with a held output
      apply_reset();
      cyc(1'b1, 0, 1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1, 6, 1'b1, 0, 5, 1'b0);
      for (int r = 0; r < 3; r++) cyc(1'b0, 0, 0, 1'b1, 1, 1000, 1'b0);
      chk("pre_reset_rdy", bus.sum_rdy, 1);
      apply_reset();
      out_log.delete();
      cyc(1'b1, 1, 6, 1'b0, 0, 0, 1'b0);
      for (int r = 0; r < 6; r++) cyc(1'b0, 0, 0, 1'b1, 1, 1, 1'b0);
      idle(2, 1'b0);
      chk("post_reset_sum", bus.sum, 6);
      chk("post_reset_ch", bus.sum_ch, 1);
      idle(3, 1'b1);
      chk("drain_empty", out_q.size(), 0);

      // saturation vs wrap at a 16-bit accumulator
      sat_drive(1'b1, 1'b0, 16'h0);
      @(posedge dram_clk); #3;
      sat_drive(1'b0, 1'b1, 16'hFFFF);
      @(posedge dram_clk); #3;
      sat_drive(1'b0, 1'b1, 16'h0002);
      @(posedge dram_clk); #3;
      chk("sat_lat_m1", bus_s1.sum_rdy, 0);
      sat_drive(1'b0, 1'b0, 16'h0);
      @(posedge dram_clk); #3;
      chk("sat1_rdy", bus_s1.sum_rdy, 1);
      chk("sat1_sum", bus_s1.sum, 16'hFFFF);
      chk("sat1_flag", bus_s1.sum_sat, 1);
      chk("sat1_ch", bus_s1.sum_ch, 0);
      chk("sat0_rdy", bus_s0.sum_rdy, 1);
      chk("sat0_sum", bus_s0.sum, 16'h0001);
      chk("sat0_flag", bus_s0.sum_sat, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
